// File: rtl/fetch_pkg.sv
// Shared IF-stage definitions: NOP encoding, default reset PC and the
// {pc, instr} record carried through the prefetch queue.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t for the IF prefetch queue; flush beats push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// RV32I IF stage: owns the PC, issues one fetch per cycle to a 1-cycle imem,
// queues returned words and hands them to decode; an execute redirect kills all younger work.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 D_WIDTH    = XLEN,
    parameter int                 FIFO_DEPTH = 2,
    parameter logic [D_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_src_e,
    input  logic [D_WIDTH-1:0] pc_target_e,
    input  logic               stall_d,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic               valid_d,
    output logic [D_WIDTH-1:0] instr_d,
    output logic [D_WIDTH-1:0] pc_d,
    output logic [D_WIDTH-1:0] pc_plus4_d
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [D_WIDTH-1:0] pc_f;
    logic               inflight;
    logic [D_WIDTH-1:0] inflight_pc;

    logic               push;
    logic               pop;
    logic               flush;
    logic [CW-1:0]      count;
    logic               empty;
    logic               full;
    logic [OW-1:0]      occupancy;
    fetch_entry_t       head;
    fetch_entry_t       entry_in;

    assign pop   = valid_d & ~stall_d & ~pc_src_e;
    assign push  = inflight & ~pc_src_e;
    assign flush = pc_src_e;

    // Slots already promised: queued + outstanding, less the one leaving this cycle.
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign imem_req  = ~rst & ~pc_src_e & (occupancy < OW'(FIFO_DEPTH));
    assign imem_addr = pc_f;

    // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (pc_src_e) begin
            pc_f     <= pc_target_e & ~D_WIDTH'(3);
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc_f        <= pc_f + D_WIDTH'(4);
                inflight_pc <= pc_f;
            end
        end
    end

    assign entry_in = '{pc: inflight_pc, instr: imem_rdata};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (entry_in),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // NOTE: every output written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        pc_d    = '0;
        if (!empty) begin
            valid_d = 1'b1;
            instr_d = head.instr;
            pc_d    = head.pc;
        end
    end

    assign pc_plus4_d = pc_d + D_WIDTH'(4);

    no_overflow: assert property (@(posedge clk) disable iff (rst) (push && !pop) |-> !full);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table covering startup,
// stall, redirects, reset and PC wrap, plus hand-written reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] TAG = 32'hA5A5_0000;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .stall_d     (stall_d),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d)
    );

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ TAG;
    end

    typedef struct {
        logic        rst;
        logic        src;
        logic [31:0] tgt;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [31:0] t, input logic st,
                       input logic rq, input logic [31:0] a, input logic v, input logic [31:0] p);
        vec_t e;
        e.rst = r; e.src = s; e.tgt = t; e.stall = st;
        e.req = rq; e.addr = a; e.valid = v; e.pc = p;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic valid, input logic [31:0] pc);
        logic [31:0] exp_instr;
        exp_instr = valid ? (pc ^ TAG) : 32'h0000_0013;
        check({tag, " valid_d"},    {31'b0, valid_d}, {31'b0, valid});
        check({tag, " pc_d"},       pc_d,       pc);
        check({tag, " instr_d"},    instr_d,    exp_instr);
        check({tag, " pc_plus4_d"}, pc_plus4_d, pc + 32'd4);
    endtask

    initial begin
        rst = 1'b1; pc_src_e = 1'b0; pc_target_e = '0; stall_d = 1'b0;
        imem_rdata = '0;

        //    rst src target        stall  req addr          valid pc
        add(0, 0, 32'h0,        0,     1, 32'h000,       0, 32'h000);   // startup
        add(0, 0, 32'h0,        0,     1, 32'h004,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h008,       1, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h00C,       1, 32'h004);
        add(0, 0, 32'h0,        0,     1, 32'h010,       1, 32'h008);
        add(0, 0, 32'h0,        1,     0, 32'h0,         1, 32'h00C);   // stall x4
        add(0, 0, 32'h0,        1,     0, 32'h0,         1, 32'h00C);
        add(0, 0, 32'h0,        1,     0, 32'h0,         1, 32'h00C);
        add(0, 0, 32'h0,        1,     0, 32'h0,         1, 32'h00C);
        add(0, 0, 32'h0,        0,     1, 32'h014,       1, 32'h00C);
        add(0, 0, 32'h0,        0,     1, 32'h018,       1, 32'h010);
        add(0, 0, 32'h0,        0,     1, 32'h01C,       1, 32'h014);
        add(0, 1, 32'h100,      0,     0, 32'h0,         1, 32'h018);   // redirect
        add(0, 0, 32'h0,        0,     1, 32'h100,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h104,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h108,       1, 32'h100);
        add(0, 0, 32'h0,        0,     1, 32'h10C,       1, 32'h104);
        add(0, 0, 32'h0,        1,     0, 32'h0,         1, 32'h108);   // fill queue
        add(0, 1, 32'h040,      1,     0, 32'h0,         1, 32'h108);   // redirect under stall
        add(0, 0, 32'h0,        0,     1, 32'h040,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h044,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h048,       1, 32'h040);
        add(0, 1, 32'h200,      0,     0, 32'h0,         1, 32'h044);   // back-to-back redirects
        add(0, 1, 32'h102,      0,     0, 32'h0,         0, 32'h000);   // misaligned target
        add(0, 0, 32'h0,        0,     1, 32'h100,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h104,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h108,       1, 32'h100);
        add(0, 0, 32'h0,        1,     0, 32'h0,         1, 32'h104);   // two queued
        add(1, 0, 32'h0,        1,     0, 32'h0,         1, 32'h104);   // reset mid-run
        add(0, 0, 32'h0,        0,     1, 32'h000,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h004,       0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h008,       1, 32'h000);
        add(0, 1, 32'hFFFF_FFF8, 0,    0, 32'h0,         1, 32'h004);   // wrap
        add(0, 0, 32'h0,        0,     1, 32'hFFFF_FFF8, 0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'hFFFF_FFFC, 0, 32'h000);
        add(0, 0, 32'h0,        0,     1, 32'h000,       1, 32'hFFFF_FFF8);
        add(0, 0, 32'h0,        0,     1, 32'h004,       1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,        0,     1, 32'h008,       1, 32'h000);

        // Initial reset: idle outputs, no fetch while rst is high.
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset imem_req", {31'b0, imem_req}, 32'd0);
        check_outputs("reset", 1'b0, 32'h0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            pc_src_e    = vecs[i].src;
            pc_target_e = vecs[i].tgt;
            stall_d     = vecs[i].stall;
            #1;
            check($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            if (vecs[i].req)
                check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
            check_outputs($sformatf("v%0d", i), vecs[i].valid, vecs[i].pc);
        end

        // Reset has priority over a simultaneous redirect.
        @(negedge clk);
        rst = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h300; stall_d = 1'b0;
        #1;
        check("rst+redirect imem_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
        #1;
        check("after rst+redirect imem_req", {31'b0, imem_req}, 32'd1);
        check("after rst+redirect imem_addr", imem_addr, 32'h0);
        check_outputs("after rst+redirect", 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("after rst+redirect 2nd addr", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage RV32I pipeline; it is the consumer of the execute stage's redirect outputs (pc_src_e, pc_target_e).
- Owns the PC register and issues one word fetch per cycle to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a small prefetch queue and presents them to decode under a stall handshake.
- A redirect kills everything younger than the redirecting instruction: queued words, in-flight fetch and the current PC.

Parameters:
- D_WIDTH, 32, address/data width.
- FIFO_DEPTH, 2, prefetch queue entries; power of 2, at least 2. Depth 2 is the minimum for 1 instr/cycle throughput.
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_src_e  in  1  redirect request from execute (taken branch/jump).
- pc_target_e  in  D_WIDTH  redirect target from execute.
- stall_d  in  1  decode cannot accept this cycle.
- imem_req  out  1  fetch issued this cycle.
- imem_addr  out  D_WIDTH  fetch address, word aligned.
- imem_rdata  in  D_WIDTH  instruction word; valid the cycle after imem_req.
- valid_d  out  1  instr_d/pc_d hold a live instruction.
- instr_d  out  D_WIDTH  instruction to decode.
- pc_d  out  D_WIDTH  PC of instr_d.
- pc_plus4_d  out  D_WIDTH  pc_d + 4, mod 2^32.

Behaviour:
- State:
  - pc_f: next fetch address.
  - inflight: 1-bit flag; inflight_pc: address of the outstanding fetch.
  - Prefetch queue of {pc, instr} pairs with count.
- Reset (any cycle, including mid-operation), next-cycle values:
  - pc_f = RESET_PC; queue empty; inflight = 0.
  - While rst is high, imem_req = 0.
  - valid_d = 0, instr_d = 32'h0000_0013 (NOP), pc_d = 0, pc_plus4_d = 4.
- Pop: pop = valid_d & ~stall_d & ~pc_src_e.
- Issue rule (no redirect, no reset): imem_req = 1 iff (count + inflight - pop) < FIFO_DEPTH.
  - imem_addr = pc_f.
  - On issue: pc_f <= pc_f + 4 (wraps mod 2^32), inflight <= 1, inflight_pc <= pc_f.
  - Otherwise inflight <= 0.
- Response:
  - If inflight is set and no redirect this cycle, push {inflight_pc, imem_rdata}.
  - Pushing and popping in the same cycle is legal.
  - The issue rule guarantees a push never overflows the queue.
- Output:
  - valid_d = (count != 0).
  - instr_d/pc_d come from the queue head.
  - When empty: instr_d = NOP, pc_d = 0.
  - No bypass: issue at cycle t gives valid_d at t+2 at the earliest.
- Stall:
  - Head is held stable while stall_d = 1.
  - Issuing stops once the queue plus in-flight reach FIFO_DEPTH.
  - No word is lost or duplicated across a stall.
- Redirect (pc_src_e = 1, checked before stall):
  - That cycle: imem_req = 0 and pop is suppressed.
  - Next cycle: queue empty, inflight = 0, pc_f = {pc_target_e[D_WIDTH-1:2], 2'b00}.
  - The in-flight response returning in the redirect cycle is discarded.
  - The first fetch of the target issues the cycle after the redirect; valid_d for it follows 2 cycles after that issue.
  - Redirect wins over stall_d.
  - Back-to-back redirects: the latest target wins.
- Misaligned target: bits [1:0] are silently cleared; no exception is raised by this block.
- rst has priority over pc_src_e.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR constant (32'h0000_0013).
  - Default RESET_PC.
  - A packed fetch_entry_t typedef {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Depth FIFO_DEPTH; push/pop/flush inputs; count, empty and full outputs.
  - flush has priority over push and pop.
- The PC, issue and kill logic stay in fetch_unit.

Test Plan:
- Startup: release rst; imem returns rdata = addr ^ 32'hA5A5_0000.
  - imem_addr is 0,4,8,… every cycle from the first cycle after release.
  - valid_d rises 2 cycles after the first issue.
  - pc_d = 0,4,8,… one per cycle with matching instr_d.
- Stall: after steady state, hold stall_d = 1 for 4 cycles with FIFO_DEPTH = 2.
  - pc_d/instr_d are frozen.
  - imem_req drops once count + inflight = 2.
  - After release, pc_d continues at the next consecutive address with no gap or duplicate.
- Redirect: pc_src_e = 1, pc_target_e = 0x100 while the queue is full and one fetch is in flight.
  - imem_req = 0 that cycle; imem_addr = 0x100 on the next cycle.
  - valid_d = 0 until 2 cycles after that issue, then pc_d = 0x100.
  - No stale word is ever presented.
- Redirect with stall: pc_src_e = 1 (target 0x40) while stall_d = 1 → identical result; the redirect is taken.
- Reset mid-run: assert rst for 1 cycle with 2 queued entries.
  - Next cycle: valid_d = 0, instr_d = 0x13.
  - The next fetch after release is at RESET_PC.
- Boundaries:
  - Target 0x102 → fetch at 0x100.
  - PC 0xFFFF_FFFC → next fetch at 0x0, and pc_plus4_d of that entry = 0x0.
